arm_mc_ctrl: RTL and testbench

ARM_MC_CTRL -- requirements
Module: arm_mc_ctrl

---
 rtl/arm_mc_pkg.sv | 58 +++++
 rtl/arm_cond_check.sv | 38 +++
 rtl/arm_mc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_arm_mc_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit.
// States, datapath mux selects, instruction classes and DP opcodes.
package arm_mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd4,
    ST_WB     = 3'd5,
    ST_IRQ    = 3'd6
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_ALU = 2'b01;
  localparam logic [1:0] PC_SEL_IRQ = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_LS  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_UND = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;

  function automatic logic [1:0] dp_alu(input logic [3:0] op);
    logic [1:0] r;
    r = ALU_ADD;
    case (op)
      OP_SUB:  r = ALU_SUB;
      OP_CMP:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_ORR:  r = ALU_ORR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Only the four arithmetic/logic ops write a register result.
  function automatic logic dp_has_wb(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluation against NZCV flags.
// Purely combinational; 1111 is treated as never.
module arm_cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM control FSM with level-sensitive IRQ entry.
// Outputs decode from state, instr and mem_ready only.
module arm_mc_ctrl
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  flags,
  input  logic        nIRQ,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic        flags_we,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  imm_src,
  output logic [1:0]  alu_ctrl,
  output logic [2:0]  state
);

  state_e state_q, state_d;
  state_e fetch_nxt;

  logic nirq_meta_q, nirq_sync_q;
  logic irq_mask_q, irq_mask_d;
  logic irq_pend;

  logic       cond_pass;
  logic       exec_ok;
  logic [1:0] cls;
  logic [3:0] opcode;
  logic       is_load;
  logic       unused_bits;

  assign cls         = instr[27:26];
  assign opcode      = instr[24:21];
  assign is_load     = instr[20];
  assign unused_bits = ^instr[19:0];

  arm_cond_check u_cond (
    .cond  (instr[31:28]),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign exec_ok   = cond_pass && (cls != CLS_UND);
  assign irq_pend  = ~nirq_sync_q & ~irq_mask_q;
  assign fetch_nxt = irq_pend ? ST_IRQ : ST_FETCH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nirq_meta_q <= 1'b1;
      nirq_sync_q <= 1'b1;
    end else begin
      nirq_meta_q <= nIRQ;
      nirq_sync_q <= nirq_meta_q;
    end
  end

  // Set on IRQ entry wins over the level re-arm.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (state_q == ST_IRQ) begin
      irq_mask_d = 1'b1;
    end else if (nirq_sync_q) begin
      irq_mask_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= 1'b0;
      state_q    <= ST_FETCH;
    end else begin
      irq_mask_q <= irq_mask_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_SEL_PC4;
    reg_we     = 1'b0;
    flags_we   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_DP;
    alu_ctrl   = ALU_ADD;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_PC4;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = exec_ok ? ST_EXEC : fetch_nxt;
        end
        ST_EXEC: begin
          unique case (cls)
            CLS_DP: begin
              alu_src  = instr[25];
              imm_src  = IMM_DP;
              alu_ctrl = dp_alu(opcode);
              flags_we = instr[20] | (opcode == OP_CMP);
              state_d  = dp_has_wb(opcode) ? ST_WB : fetch_nxt;
            end
            CLS_LS: begin
              alu_src  = 1'b1;
              imm_src  = IMM_MEM;
              alu_ctrl = instr[23] ? ALU_ADD : ALU_SUB;
              state_d  = is_load ? ST_MEMRD : ST_MEMWR;
            end
            CLS_BR: begin
              alu_src  = 1'b1;
              imm_src  = IMM_BR;
              alu_ctrl = ALU_ADD;
              pc_we    = 1'b1;
              pc_sel   = PC_SEL_ALU;
              state_d  = fetch_nxt;
            end
            CLS_UND: begin
              state_d = fetch_nxt;
            end
          endcase
        end
        ST_MEMRD: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            state_d = ST_WB;
          end
        end
        ST_MEMWR: begin
          mem_write = 1'b1;
          if (mem_ready) begin
            state_d = fetch_nxt;
          end
        end
        ST_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (cls == CLS_LS) && is_load;
          state_d    = fetch_nxt;
        end
        ST_IRQ: begin
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_IRQ;
          state_d = ST_FETCH;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Directed bench for arm_mc_ctrl: per-cycle state and strobe vectors.
// Vector = {state, ir_we, pc_we, pc_sel, reg_we, flags_we, mem_read, mem_write, mem_to_reg, alu_src, imm_src, alu_ctrl}.
module tb_arm_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        nIRQ;
  logic        mem_ready;
  logic        ir_we, pc_we, reg_we, flags_we;
  logic        mem_read, mem_write, mem_to_reg, alu_src;
  logic [1:0]  pc_sel, imm_src, alu_ctrl;
  logic [2:0]  state;

  always #5 clk = ~clk;

  arm_mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .flags      (flags),
    .nIRQ       (nIRQ),
    .mem_ready  (mem_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .reg_we     (reg_we),
    .flags_we   (flags_we),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .state      (state)
  );

  logic [16:0] obs;
  assign obs = {state, ir_we, pc_we, pc_sel, reg_we, flags_we,
                mem_read, mem_write, mem_to_reg, alu_src,
                imm_src, alu_ctrl};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [16:0] got,
                     input logic [16:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic logic [16:0] ev(
    input logic [2:0] st, input logic irw, input logic pcw,
    input logic [1:0] pcs, input logic rw, input logic fw,
    input logic mr, input logic mw, input logic m2r,
    input logic as, input logic [1:0] is, input logic [1:0] ac);
    return {st, irw, pcw, pcs, rw, fw, mr, mw, m2r, as, is, ac};
  endfunction

  // Check at +3ns after the edge, then return at +2ns after the next.
  task automatic cyc(input string tag, input logic [16:0] want);
    #1;
    chk(tag, obs, want);
    @(posedge clk);
    #2;
  endtask

  logic [16:0] F_RDY, F_WAIT, D_V, WB_DP, WB_LD, IRQV;
  logic [16:0] EX_ADD, EX_ADDSI, EX_SUB, EX_ORR, EX_CMP;
  logic [16:0] EX_LDU, EX_LDD, EX_BR, MRD, MWR;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    F_RDY    = ev(3'd0, 1, 1, 2'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
    F_WAIT   = ev(3'd0, 0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
    D_V      = ev(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    WB_DP    = ev(3'd5, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    WB_LD    = ev(3'd5, 0, 0, 2'd0, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0);
    IRQV     = ev(3'd6, 0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    EX_ADD   = ev(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    EX_ADDSI = ev(3'd2, 0, 0, 2'd0, 0, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    EX_SUB   = ev(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1);
    EX_ORR   = ev(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3);
    EX_CMP   = ev(3'd2, 0, 0, 2'd0, 0, 1, 0, 0, 0, 1, 2'd0, 2'd1);
    EX_LDU   = ev(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0);
    EX_LDD   = ev(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd1);
    EX_BR    = ev(3'd2, 0, 1, 2'd1, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
    MRD      = ev(3'd3, 0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
    MWR      = ev(3'd4, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0);

    reset = 1'b1;
    instr = 32'hE082_1003;
    flags = 4'b0000;
    nIRQ = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #2;
    cyc("rst_a", 17'd0);
    cyc("rst_b", 17'd0);
    reset = 1'b0;

    // ADD R1,R2,R3
    cyc("add_f", F_RDY);
    cyc("add_d", D_V);
    cyc("add_e", EX_ADD);
    cyc("add_wb", WB_DP);

    // ADDS R1,R2,#5
    instr = 32'hE292_1005;
    cyc("adds_f", F_RDY);
    cyc("adds_d", D_V);
    cyc("adds_e", EX_ADDSI);
    cyc("adds_wb", WB_DP);

    instr = 32'hE042_1003;
    cyc("sub_f", F_RDY);
    cyc("sub_d", D_V);
    cyc("sub_e", EX_SUB);
    cyc("sub_wb", WB_DP);

    instr = 32'hE182_1003;
    cyc("orr_f", F_RDY);
    cyc("orr_d", D_V);
    cyc("orr_e", EX_ORR);
    cyc("orr_wb", WB_DP);

    // CMP R1,#5: 3 cycles, no WB
    instr = 32'hE351_0005;
    cyc("cmp_f", F_RDY);
    cyc("cmp_d", D_V);
    cyc("cmp_e", EX_CMP);

    // Unsupported DP opcode (MOV) retires from EXEC
    instr = 32'hE1A0_1003;
    cyc("mov_f", F_RDY);
    cyc("mov_d", D_V);
    cyc("mov_e", EX_ADD);

    // LDR with three wait cycles in MEMRD
    instr = 32'hE592_1004;
    cyc("ldr_f", F_RDY);
    cyc("ldr_d", D_V);
    cyc("ldr_e", EX_LDU);
    mem_ready = 1'b0;
    cyc("ldr_w1", MRD);
    cyc("ldr_w2", MRD);
    cyc("ldr_w3", MRD);
    mem_ready = 1'b1;
    cyc("ldr_m", MRD);
    cyc("ldr_wb", WB_LD);

    // LDR with U=0 subtracts the offset
    instr = 32'hE512_1004;
    cyc("ldrd_f", F_RDY);
    cyc("ldrd_d", D_V);
    cyc("ldrd_e", EX_LDD);
    cyc("ldrd_m", MRD);
    cyc("ldrd_wb", WB_LD);

    // FETCH wait
    mem_ready = 1'b0;
    instr = 32'hE582_1004;
    cyc("fw", F_WAIT);
    mem_ready = 1'b1;
    cyc("str_f", F_RDY);
    cyc("str_d", D_V);
    cyc("str_e", EX_LDU);
    cyc("str_m", MWR);

    // BEQ not taken, then taken
    instr = 32'h0A00_0010;
    flags = 4'b0000;
    cyc("beqn_f", F_RDY);
    cyc("beqn_d", D_V);
    flags = 4'b0100;
    cyc("beqt_f", F_RDY);
    cyc("beqt_d", D_V);
    cyc("beqt_e", EX_BR);

    // Other conditions: GT fails with N!=V, passes with clear flags; HI
    instr = 32'hC082_1003;
    flags = 4'b1000;
    cyc("gtn_f", F_RDY);
    cyc("gtn_d", D_V);
    flags = 4'b0000;
    cyc("gtt_f", F_RDY);
    cyc("gtt_d", D_V);
    cyc("gtt_e", EX_ADD);
    cyc("gtt_wb", WB_DP);
    instr = 32'h8082_1003;
    flags = 4'b0110;
    cyc("hin_f", F_RDY);
    cyc("hin_d", D_V);
    flags = 4'b0010;
    cyc("hit_f", F_RDY);
    cyc("hit_d", D_V);
    cyc("hit_e", EX_ADD);
    cyc("hit_wb", WB_DP);

    // Class 11 and cond NV: 2 cycles each
    instr = 32'hEC00_0000;
    cyc("und_f", F_RDY);
    cyc("und_d", D_V);
    instr = 32'hF082_1003;
    cyc("nv_f", F_RDY);
    cyc("nv_d", D_V);

    // IRQ raised during STR EXEC, taken after MEMWR
    instr = 32'hE582_1004;
    cyc("is_f", F_RDY);
    cyc("is_d", D_V);
    nIRQ = 1'b0;
    cyc("is_e", EX_LDU);
    mem_ready = 1'b0;
    cyc("is_w1", MWR);
    cyc("is_w2", MWR);
    mem_ready = 1'b1;
    cyc("is_m", MWR);
    cyc("is_irq", IRQV);

    // nIRQ still low: ADD runs without a second IRQ
    instr = 32'hE082_1003;
    cyc("im_f", F_RDY);
    cyc("im_d", D_V);
    cyc("im_e", EX_ADD);
    cyc("im_wb", WB_DP);

    // Re-arm by raising nIRQ, then lower it again
    instr = 32'hF082_1003;
    nIRQ = 1'b1;
    cyc("ra_f", F_RDY);
    cyc("ra_d", D_V);
    nIRQ = 1'b0;
    cyc("rb_f", F_RDY);
    cyc("rb_d", D_V);
    cyc("rc_f", F_RDY);
    cyc("rc_d", D_V);
    cyc("rc_irq", IRQV);
    cyc("rc_post", F_RDY);
    cyc("rc_d2", D_V);
    nIRQ = 1'b1;

    // Reset pulsed during MEMRD
    instr = 32'hE592_1004;
    cyc("rl_f", F_RDY);
    cyc("rl_d", D_V);
    cyc("rl_e", EX_LDU);
    mem_ready = 1'b0;
    #1;
    chk("rl_m", obs, MRD);
    reset = 1'b1;
    #1;
    chk("rl_rst_now", obs, 17'd0);
    @(posedge clk);
    #2;
    cyc("rl_rst_hold", 17'd0);
    reset = 1'b0;
    cyc("rl_after", F_WAIT);
    mem_ready = 1'b1;
    cyc("rl_f2", F_RDY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
